// File: rtl/regfile_arbiter_if.sv
// Single requester port of the register-file arbiter: a level request with
// its access fields, answered by one-cycle grant and completion pulses.
interface regfile_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter serialising single read/write accesses from two ports
// onto one 16 x 8 register file; every grant is followed by a done pulse.
module regfile_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    regfile_arbiter_if.slave  a,
    regfile_arbiter_if.slave  b,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t state_r;
    logic   last_grant_r;
    logic   sel_r;
    logic   we_q;
    logic   win_a_s;
    logic   win_b_s;

    // Winner selection: a tie goes to the port that did not win last time.
    always_comb begin
        win_a_s = 1'b0;
        win_b_s = 1'b0;
        if (a.req && (!b.req || (last_grant_r == PORT_B))) begin
            win_a_s = 1'b1;
        end else if (b.req) begin
            win_b_s = 1'b1;
        end else begin
            win_b_s = 1'b0;
        end
    end

    // Access sequencer with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            last_grant_r <= PORT_B;
            sel_r        <= PORT_A;
            we_q         <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_addr     <= {ADDR_W{1'b0}};
            reg_wr_data  <= {DATA_W{1'b0}};
            busy         <= 1'b0;
            a.gnt        <= 1'b0;
            a.done       <= 1'b0;
            a.rdata      <= {DATA_W{1'b0}};
            b.gnt        <= 1'b0;
            b.done       <= 1'b0;
            b.rdata      <= {DATA_W{1'b0}};
        end else begin
            a.gnt     <= 1'b0;
            a.done    <= 1'b0;
            b.gnt     <= 1'b0;
            b.done    <= 1'b0;
            reg_wr_en <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (win_a_s) begin
                        sel_r        <= PORT_A;
                        last_grant_r <= PORT_A;
                        we_q         <= a.we;
                        reg_addr     <= a.addr;
                        reg_wr_data  <= a.wdata;
                        reg_wr_en    <= a.we;
                        a.gnt        <= 1'b1;
                        busy         <= 1'b1;
                        state_r      <= S_ACCESS;
                    end else if (win_b_s) begin
                        sel_r        <= PORT_B;
                        last_grant_r <= PORT_B;
                        we_q         <= b.we;
                        reg_addr     <= b.addr;
                        reg_wr_data  <= b.wdata;
                        reg_wr_en    <= b.we;
                        b.gnt        <= 1'b1;
                        busy         <= 1'b1;
                        state_r      <= S_ACCESS;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    // reg_rd_data reflects reg_addr this cycle; only the owner's rdata moves.
                    if (sel_r == PORT_A) begin
                        a.done <= 1'b1;
                        if (!we_q) begin
                            a.rdata <= reg_rd_data;
                        end else begin
                            a.rdata <= a.rdata;
                        end
                    end else begin
                        b.done <= 1'b1;
                        if (!we_q) begin
                            b.rdata <= reg_rd_data;
                        end else begin
                            b.rdata <= b.rdata;
                        end
                    end
                    busy    <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16 x 8 register file.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic [7:0] mem [16];
    int         checks = 0;
    int         errors = 0;

    regfile_arbiter_if #(.ADDR_W(4), .DATA_W(8)) a_if ();
    regfile_arbiter_if #(.ADDR_W(4), .DATA_W(8)) b_if ();

    regfile_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if),
        .b           (b_if),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    end
    assign reg_rd_data = mem[reg_addr];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_a_gnt"}, a_if.gnt, 0);
        check_val({tag, "_b_gnt"}, b_if.gnt, 0);
        check_val({tag, "_a_done"}, a_if.done, 0);
        check_val({tag, "_b_done"}, b_if.done, 0);
        check_val({tag, "_a_rdata"}, a_if.rdata, 0);
        check_val({tag, "_b_rdata"}, b_if.rdata, 0);
        check_val({tag, "_wr_en"}, reg_wr_en, 0);
        check_val({tag, "_addr"}, reg_addr, 0);
        check_val({tag, "_wdata"}, reg_wr_data, 0);
    endtask

    // Continuous exclusivity checks, sampled away from the active edge.
    always @(negedge clk) begin
        check_val("gnt_excl", a_if.gnt & b_if.gnt, 0);
        check_val("done_excl", a_if.done & b_if.done, 0);
        check_val("wren_outside_access", reg_wr_en & ~(a_if.gnt | b_if.gnt), 0);
    end

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 4'h0; a_if.wdata = 8'h00;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 4'h0; b_if.wdata = 8'h00;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // A writes 0x3 = 0xA5
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 4'h3; a_if.wdata = 8'hA5;
        step();
        check_val("wr_a_gnt", a_if.gnt, 1);
        check_val("wr_b_gnt", b_if.gnt, 0);
        check_val("wr_wren", reg_wr_en, 1);
        check_val("wr_addr", reg_addr, 4'h3);
        check_val("wr_wdata", reg_wr_data, 8'hA5);
        check_val("wr_busy1", busy, 1);
        a_if.req = 1'b0;
        step();
        check_val("wr_a_done", a_if.done, 1);
        check_val("wr_b_done", b_if.done, 0);
        check_val("wr_b_rdata", b_if.rdata, 0);
        check_val("wr_wren_done", reg_wr_en, 0);
        check_val("wr_busy2", busy, 1);
        step();
        check_val("wr_busy3", busy, 0);

        // B reads 0x3
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 4'h3;
        step();
        check_val("rd_b_gnt", b_if.gnt, 1);
        check_val("rd_wren", reg_wr_en, 0);
        b_if.req = 1'b0;
        step();
        check_val("rd_b_done", b_if.done, 1);
        check_val("rd_b_rdata", b_if.rdata, 8'hA5);
        check_val("rd_a_rdata", a_if.rdata, 0);
        step();

        // Tie from reset: A writes 1=0x11, B writes 2=0x22, both held for 4 accesses
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 4'h1; a_if.wdata = 8'h11;
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 4'h2; b_if.wdata = 8'h22;
        for (int c = 0; c < 12; c++) begin
            step();
            check_val($sformatf("tie_a_gnt_%0d", c), a_if.gnt, ((c % 3) == 0) && (((c / 3) % 2) == 0));
            check_val($sformatf("tie_b_gnt_%0d", c), b_if.gnt, ((c % 3) == 0) && (((c / 3) % 2) == 1));
        end
        a_if.req = 1'b0; b_if.req = 1'b0;
        step();

        // A writes 7=0x3C while B reads 7; last winner was B so A goes first
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 4'h7; a_if.wdata = 8'h3C;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 4'h7;
        step();
        check_val("raw_a_gnt", a_if.gnt, 1);
        check_val("raw_b_gnt1", b_if.gnt, 0);
        a_if.req = 1'b0;
        step();
        check_val("raw_a_done", a_if.done, 1);
        step();
        check_val("raw_idle_busy", busy, 0);
        step();
        check_val("raw_b_gnt", b_if.gnt, 1);
        b_if.req = 1'b0;
        step();
        check_val("raw_b_done", b_if.done, 1);
        check_val("raw_b_rdata", b_if.rdata, 8'h3C);
        step();

        // Reset during S_ACCESS of a B read
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 4'h1;
        step();
        check_val("mid_b_gnt", b_if.gnt, 1);
        b_if.req = 1'b0;
        rst = 1'b1;
        step();
        check_all_zero("mid_rst");
        rst = 1'b0;
        step();
        check_val("mid_no_done", b_if.done, 0);
        check_val("mid_busy", busy, 0);
        b_if.req = 1'b1;
        step();
        check_val("mid_re_gnt", b_if.gnt, 1);
        b_if.req = 1'b0;
        step();
        check_val("mid_re_done", b_if.done, 1);
        check_val("mid_re_rdata", b_if.rdata, 8'h11);
        step();

        // B streams reads of 0x2; A joins late and wins the next idle
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 4'h2;
        for (int s = 1; s <= 8; s++) begin
            step();
            check_val($sformatf("strm_gnt_%0d", s), b_if.gnt, (s % 3) == 1);
            check_val($sformatf("strm_done_%0d", s), b_if.done, (s % 3) == 2);
            check_val($sformatf("strm_busy_%0d", s), busy, (s % 3) != 0);
        end
        check_val("strm_rdata", b_if.rdata, 8'h22);
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 4'h1;
        step();
        check_val("late_idle_a_gnt", a_if.gnt, 0);
        step();
        check_val("late_a_gnt", a_if.gnt, 1);
        check_val("late_b_gnt", b_if.gnt, 0);
        a_if.req = 1'b0;
        step();
        check_val("late_a_done", a_if.done, 1);
        check_val("late_a_rdata", a_if.rdata, 8'h11);
        check_val("late_b_rdata", b_if.rdata, 8'h22);
        step();
        step();
        check_val("late_b_regnt", b_if.gnt, 1);
        b_if.req = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
